replay_spike_timer: RTL and testbench
=====================================

REPLAY_SPIKE_TIMER -- requirements
Module: replay_spike_timer

Interface
REQ-001 Parameter P, default 64: number of spike lines per replay beat.
REQ-002 Parameter WINDOW, default 8: time steps (accepted beats) per phase.
REQ-003 Parameter NUM_PHASES, default 2: multiplexed phases per gamma cycle.
REQ-004 Parameter TW, default $clog2(WINDOW)+1: bits per spike-time field.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 grst  input  1  reset, asynchronous, active-high.
REQ-007 gamma_start  input  1  single-cycle pulse; starts a new gamma cycle at phase 0.
REQ-008 spikes_in  input  P  replayed spike vector, one time step per accepted beat.
REQ-009 valid_in  input  1  spikes_in carries a time step.
REQ-010 in_ready  output  1  block accepts a beat; beat accepted when valid_in && in_ready.
REQ-011 spike_time  output  P*TW  per-line first-spike time; line i at bits [i*TW +: TW].
REQ-012 phase_id  output  $clog2(NUM_PHASES) (min 1)  phase of the current capture or hold.
REQ-013 times_valid  output  1  spike_time/phase_id hold a complete phase result.
REQ-014 out_ready  input  1  consumer takes result; transfer when times_valid && out_ready.
REQ-015 overrun  output  1  sticky: gamma_start arrived outside IDLE.

Function
REQ-016 FSM states IDLE, CAPTURE, HOLD; in_ready = (state==CAPTURE); times_valid = (state==HOLD).
REQ-017 IDLE + gamma_start -> CAPTURE; phase_id=0, step=0, all spike_time fields = WINDOW, all per-line fired flags cleared.
REQ-018 CAPTURE, accepted beat: each line i with spikes_in[i]=1 and fired[i]=0 gets spike_time[i]=step, fired[i]=1; later spikes on a fired line are ignored.
REQ-019 CAPTURE, accepted beat: step increments; the beat with step==WINDOW-1 is the last of the phase, next state HOLD.
REQ-020 CAPTURE, valid_in=0: no state change; step holds.
REQ-021 A line with no spike in the phase reads WINDOW (no-spike code); field values 0..WINDOW-1 are spike times.
REQ-022 Latency: result visible with times_valid=1 on the cycle after the last accepted beat.
REQ-023 HOLD: spike_time and phase_id stable until transfer; valid_in ignored (in_ready=0).
REQ-024 HOLD transfer with phase_id<NUM_PHASES-1 -> CAPTURE next cycle, phase_id+1, step=0, fields reset to WINDOW, fired cleared.
REQ-025 HOLD transfer with phase_id==NUM_PHASES-1 -> IDLE; phase_id returns 0; spike_time holds last values.
REQ-026 gamma_start in CAPTURE or HOLD: set overrun=1, abort the current result (no transfer), restart as in REQ-017 on the next cycle.
REQ-027 gamma_start coincident with a HOLD transfer: restart wins; overrun set.
REQ-028 overrun clears only on grst.
REQ-029 step counter width $clog2(WINDOW)+1; never exceeds WINDOW-1 when stored to a field.

Reset
REQ-030 grst asserted (any time, asynchronously): state=IDLE, step=0, phase_id=0, all spike_time fields = WINDOW, fired=0, in_ready=0, times_valid=0, overrun=0.
REQ-031 grst mid-CAPTURE or mid-HOLD discards the partial result; no times_valid pulse follows.
REQ-032 First gamma_start accepted on the first clock edge after grst deasserts.

Verification
REQ-033 P=4, WINDOW=8: gamma_start, 8 beats, line0 spikes at step 2 and 5, line3 at step 7, others silent, out_ready=1 -> times_valid one cycle after beat 8, phase_id=0, spike_time = {8,8,7... }: line0=2, line1=8, line2=8, line3=7.
REQ-034 Same, then 8 more beats with all lines high at step 0 -> phase_id=1 result all fields 0, then IDLE, in_ready=0.
REQ-035 out_ready=0 for 5 cycles in HOLD -> times_valid stays 1, outputs unchanged, valid_in beats not accepted; transfer on first out_ready=1.
REQ-036 valid_in gaps (alternate cycles low) -> identical spike_time to gap-free run; only step count, not cycles, measured.
REQ-037 gamma_start at step 4 of phase 0 -> overrun=1, no result for aborted phase, restarted phase 0 produces correct fresh times.
REQ-038 grst pulse mid-HOLD -> all outputs to reset values within the same cycle, overrun=0, no further times_valid until next gamma_start plus 8 beats.

Source files
------------

// File: rtl/replay_spike_timer.sv
// Replay spike timer: latches the first-spike step of each line per phase; result valid the cycle after the last beat.
// Input is stalled (in_ready=0) while a result waits in HOLD; HOLD stays until out_ready; gamma_start always restarts at phase 0.
module replay_spike_timer #(
   parameter int P          = 64,
   parameter int WINDOW     = 8,
   parameter int NUM_PHASES = 2,
   parameter int TW         = $clog2(WINDOW) + 1,
   parameter int PW         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic            clk,
   input  logic            grst,
   input  logic            gamma_start,
   input  logic [P-1:0]    spikes_in,
   input  logic            valid_in,
   output logic            in_ready,
   output logic [P*TW-1:0] spike_time,
   output logic [PW-1:0]   phase_id,
   output logic            times_valid,
   input  logic            out_ready,
   output logic            overrun
);

   localparam int SW = $clog2(WINDOW) + 1;
   localparam logic [TW-1:0] NO_SPIKE  = TW'(WINDOW);
   localparam logic [SW-1:0] LAST_STEP = SW'(WINDOW - 1);
   localparam logic [PW-1:0] LAST_PH   = PW'(NUM_PHASES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] step;
   logic [P-1:0]  fired;
   logic          restart;
   logic          next_phase;
   logic          go_idle;
   logic          accept;

   always_ff @(posedge clk or posedge grst) begin
      if (grst) state <= IDLE;
      else      state <= state_nxt;
   end

   // gamma_start takes priority over any beat or transfer in the same cycle.
   always_comb begin
      state_nxt  = state;
      restart    = 1'b0;
      next_phase = 1'b0;
      go_idle    = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (gamma_start) begin
               restart   = 1'b1;
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (gamma_start) begin
               restart   = 1'b1;
               state_nxt = CAPTURE;
            end else if (valid_in) begin
               accept = 1'b1;
               if (step == LAST_STEP) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (gamma_start) begin
               restart   = 1'b1;
               state_nxt = CAPTURE;
            end else if (out_ready) begin
               if (phase_id == LAST_PH) begin
                  go_idle   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  next_phase = 1'b1;
                  state_nxt  = CAPTURE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         step       <= '0;
         phase_id   <= '0;
         fired      <= '0;
         spike_time <= {P{NO_SPIKE}};
      end else if (restart || next_phase) begin
         step       <= '0;
         phase_id   <= restart ? '0 : PW'(phase_id + 1'b1);
         fired      <= '0;
         spike_time <= {P{NO_SPIKE}};
      end else if (go_idle) begin
         phase_id <= '0;
      end else if (accept) begin
         step <= SW'(step + 1'b1);
         for (int i = 0; i < P; i++) begin
            if (spikes_in[i] && !fired[i]) begin
               spike_time[i*TW +: TW] <= TW'(step);
               fired[i]               <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge grst) begin
      if (grst)                              overrun <= 1'b0;
      else if (gamma_start && state != IDLE) overrun <= 1'b1;
   end

   assign in_ready    = (state == CAPTURE);
   assign times_valid = (state == HOLD);

endmodule

// File: tb/tb_replay_spike_timer.sv
// Directed bench for replay_spike_timer with P=4, WINDOW=8, NUM_PHASES=2.
module tb_replay_spike_timer;

   logic        clk = 1'b0;
   logic        grst;
   logic        gamma_start;
   logic [3:0]  spikes_in;
   logic        valid_in;
   logic        in_ready;
   logic [15:0] spike_time;
   logic [0:0]  phase_id;
   logic        times_valid;
   logic        out_ready;
   logic        overrun;

   int tests = 0;
   int fails = 0;

   replay_spike_timer #(.P(4), .WINDOW(8), .NUM_PHASES(2)) dut (
      .clk         (clk),
      .grst        (grst),
      .gamma_start (gamma_start),
      .spikes_in   (spikes_in),
      .valid_in    (valid_in),
      .in_ready    (in_ready),
      .spike_time  (spike_time),
      .phase_id    (phase_id),
      .times_valid (times_valid),
      .out_ready   (out_ready),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [3:0] v);
      spikes_in = v;
      valid_in  = 1'b1;
      tick();
      valid_in  = 1'b0;
      spikes_in = 4'h0;
   endtask

   task automatic hold_check(input string tag, input logic [15:0] times, input logic ph);
      check({tag, "_tv"}, {31'd0, times_valid}, 32'd1);
      check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_ph"}, {31'd0, phase_id}, {31'd0, ph});
      check({tag, "_st"}, {16'd0, spike_time}, {16'd0, times});
   endtask

   task automatic fresh_check(input string tag, input logic ph);
      check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_tv"}, {31'd0, times_valid}, 32'd0);
      check({tag, "_ph"}, {31'd0, phase_id}, {31'd0, ph});
      check({tag, "_st"}, {16'd0, spike_time}, 32'h8888);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat0 [8];
      logic [3:0] pat1 [8];
      pat0 = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h8};
      pat1 = '{4'hF, 4'h5, 4'hF, 4'h0, 4'hA, 4'hF, 4'h0, 4'hF};

      grst = 1'b1; gamma_start = 1'b0; spikes_in = 4'h0; valid_in = 1'b0; out_ready = 1'b0;
      tick(); tick();
      check("rst_rdy", {31'd0, in_ready}, 32'd0);
      check("rst_tv", {31'd0, times_valid}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      check("rst_ph", {31'd0, phase_id}, 32'd0);
      check("rst_st", {16'd0, spike_time}, 32'h8888);
      grst = 1'b0;

      // Basic phase 0, then stall in HOLD with valid_in driven.
      gamma_start = 1'b1; tick(); gamma_start = 1'b0;
      fresh_check("start", 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("pre_last_tv", {31'd0, times_valid}, 32'd0);
         beat(pat0[i]);
      end
      hold_check("ph0", 16'h7882, 1'b0);
      for (int i = 0; i < 5; i++) begin
         spikes_in = 4'hF; valid_in = 1'b1;
         tick();
         hold_check("stall", 16'h7882, 1'b0);
      end
      valid_in = 1'b0; spikes_in = 4'h0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      fresh_check("ph1_start", 1'b1);
      for (int i = 0; i < 8; i++) beat(pat1[i]);
      hold_check("ph1", 16'h0000, 1'b1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("idle_rdy", {31'd0, in_ready}, 32'd0);
      check("idle_tv", {31'd0, times_valid}, 32'd0);
      check("idle_ph", {31'd0, phase_id}, 32'd0);
      check("idle_st", {16'd0, spike_time}, 32'h0000);
      check("idle_ovr", {31'd0, overrun}, 32'd0);

      // Same phase-0 pattern with idle cycles between beats.
      gamma_start = 1'b1; tick(); gamma_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         beat(pat0[i]);
         if (i < 7) begin
            spikes_in = 4'hF; tick(); spikes_in = 4'h0;
         end
      end
      hold_check("gap", 16'h7882, 1'b0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      for (int i = 0; i < 8; i++) beat(4'h0);
      hold_check("silent", 16'h8888, 1'b1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("idle2_rdy", {31'd0, in_ready}, 32'd0);

      // Abort at step 4 of phase 0.
      gamma_start = 1'b1; tick(); gamma_start = 1'b0;
      for (int i = 0; i < 4; i++) beat(i == 1 ? 4'h2 : 4'h0);
      check("pre_abort_ovr", {31'd0, overrun}, 32'd0);
      gamma_start = 1'b1; tick(); gamma_start = 1'b0;
      check("abort_ovr", {31'd0, overrun}, 32'd1);
      fresh_check("abort", 1'b0);
      for (int i = 0; i < 8; i++) beat(i == 0 ? 4'h4 : (i == 3 ? 4'h2 : 4'h0));
      hold_check("restart", 16'h8038, 1'b0);

      // Restart coincident with a HOLD transfer.
      gamma_start = 1'b1; out_ready = 1'b1; tick(); gamma_start = 1'b0; out_ready = 1'b0;
      fresh_check("coinc", 1'b0);
      for (int i = 0; i < 8; i++) beat(i == 6 ? 4'h9 : 4'h0);
      hold_check("coinc_res", 16'h6886, 1'b0);
      check("coinc_ovr", {31'd0, overrun}, 32'd1);

      // Asynchronous reset mid-HOLD.
      grst = 1'b1; #1;
      check("arst_tv", {31'd0, times_valid}, 32'd0);
      check("arst_rdy", {31'd0, in_ready}, 32'd0);
      check("arst_ovr", {31'd0, overrun}, 32'd0);
      check("arst_st", {16'd0, spike_time}, 32'h8888);
      #1 grst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_tv", {31'd0, times_valid}, 32'd0);
      end
      out_ready = 1'b0;

      // Overrun from HOLD without transfer.
      gamma_start = 1'b1; tick(); gamma_start = 1'b0;
      fresh_check("rst_start", 1'b0);
      for (int i = 0; i < 8; i++) beat(4'h0);
      hold_check("rst_res", 16'h8888, 1'b0);
      check("hold_pre_ovr", {31'd0, overrun}, 32'd0);
      gamma_start = 1'b1; tick(); gamma_start = 1'b0;
      check("hold_ovr", {31'd0, overrun}, 32'd1);
      fresh_check("hold_abort", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
